rx_serial_7e1: RTL and testbench

- UART receiver for 7E1 frames: 1 start bit, 7 data bits LSB first, even parity, 1 stop bit.
- Receive counterpart of tx_serial_7E1 on the same serial link. Used for host-to-board ASCII commands, for example changing the measurement mode or resetting the servos.
- Presents each received character as a held register with a data-valid flag and a one-cycle completion pulse.
- Reports parity, framing and overrun errors.

---
 rtl/rx_serial_7e1.sv | 185 ++++++++++++++++++
 tb/tb_rx_serial_7e1.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7e1.sv
// 7E1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM, held character register with error flags.
// Optional macro RX_PARITY_CHECK_EN enables the even-parity check; without it the parity bit is sampled and ignored.
module rx_serial_7e1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_CNT        = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebe,
  output logic [6:0] dado_recebido,
  output logic       tem_dado,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic       overrun,
  output logic [3:0] db_estado
);

  localparam logic [3:0] INICIAL    = 4'd0;
  localparam logic [3:0] MEIO_START = 4'd1;
  localparam logic [3:0] DADOS      = 4'd2;
  localparam logic [3:0] PARIDADE   = 4'd3;
  localparam logic [3:0] STOP       = 4'd4;
  localparam logic [3:0] FINAL      = 4'd5;

  localparam logic [N_CNT-1:0] HALF_LAST = N_CNT'(CLKS_PER_BIT / 2 - 1);
  localparam logic [N_CNT-1:0] FULL_LAST = N_CNT'(CLKS_PER_BIT - 1);

  logic             sync_meta;
  logic             rx_s;
  logic [3:0]       state;
  logic [N_CNT-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [6:0]       shift;
  logic             stop_bit;
  logic             armed;
  logic             tick_half;
  logic             tick_full;
  logic             perr;
  logic             ferr;
  logic             frame_ok;
  logic             in_final;

  // Synchronizer resets to idle level so reset never looks like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      sync_meta <= entrada_serial;
      rx_s      <= sync_meta;
    end
  end

  assign tick_half = (cnt == HALF_LAST);
  assign tick_full = (cnt == FULL_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= INICIAL;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      stop_bit <= 1'b0;
      armed    <= 1'b0;
    end else begin
      case (state)
        INICIAL: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            state <= MEIO_START;
          end
        end
        MEIO_START: begin
          if (tick_half) begin
            cnt   <= '0;
            state <= rx_s ? INICIAL : DADOS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DADOS: begin
          if (tick_full) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[6:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd6) begin
              state <= PARIDADE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (tick_full) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_full) begin
            cnt      <= '0;
            stop_bit <= rx_s;
            state    <= FINAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINAL: begin
          state <= INICIAL;
          // A low stop bit means the line may still be in break; wait for idle before re-arming.
          if (!stop_bit) begin
            armed <= 1'b0;
          end
        end
        default: begin
          state <= INICIAL;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef RX_PARITY_CHECK_EN
  logic parity_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (state == PARIDADE && tick_full) begin
      parity_bit <= rx_s;
    end
  end

  assign perr = ^{shift, parity_bit};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_paridade <= 1'b0;
    end else if (in_final) begin
      erro_paridade <= perr;
    end
  end
`else
  assign perr          = 1'b0;
  assign erro_paridade = 1'b0;
`endif

  assign ferr     = ~stop_bit;
  assign frame_ok = ~perr & ~ferr;
  assign in_final = (state == FINAL);

  // A valid frame's set wins over a same-cycle acknowledge; the ack still clears overrun.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado_recebido <= '0;
      tem_dado      <= 1'b0;
      pronto        <= 1'b0;
      erro_frame    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      pronto <= in_final & frame_ok;
      if (in_final) begin
        erro_frame <= ferr;
      end
      if (in_final && frame_ok) begin
        dado_recebido <= shift;
        tem_dado      <= 1'b1;
        overrun       <= ~recebe & (overrun | tem_dado);
      end else if (recebe) begin
        tem_dado <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

  assign db_estado = state;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed testbench for rx_serial_7e1 with CLKS_PER_BIT = 4; frames are bit-banged on entrada_serial.
module tb_rx_serial_7e1;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic       recebe = 1'b0;
  logic [6:0] dado_recebido;
  logic       tem_dado;
  logic       pronto;
  logic       erro_paridade;
  logic       erro_frame;
  logic       overrun;
  logic [3:0] db_estado;

  int tests = 0;
  int failed = 0;
  int pronto_cnt = 0;

  rx_serial_7e1 #(.CLKS_PER_BIT(CPB), .N_CNT(3)) dut (
    .clock(clock),
    .reset(reset),
    .entrada_serial(entrada_serial),
    .recebe(recebe),
    .dado_recebido(dado_recebido),
    .tem_dado(tem_dado),
    .pronto(pronto),
    .erro_paridade(erro_paridade),
    .erro_frame(erro_frame),
    .overrun(overrun),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pronto === 1'b1) pronto_cnt++;
  end

  // Called on a negedge; drives start, 7 data bits LSB first, parity, stop; returns 40 negedges later.
  task automatic send_frame(input logic [6:0] ch, input logic par, input logic stp);
    logic [9:0] bits;
    bits = {stp, par, ch, 1'b0};
    for (int i = 0; i < 10; i++) begin
      entrada_serial = bits[i];
      repeat (CPB) @(negedge clock);
    end
    entrada_serial = 1'b1;
    $display("[TB] sent char 0x%h parity %b stop %b", ch, par, stp);
  endtask

  task automatic pulse_recebe();
    recebe = 1'b1;
    @(negedge clock);
    recebe = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    tests++; if (dado_recebido !== 7'h00) begin failed++; $display("FAIL reset_dado: got %h want 00", dado_recebido); end
    tests++; if (tem_dado !== 1'b0) begin failed++; $display("FAIL reset_tem_dado: got %b want 0", tem_dado); end
    tests++; if (pronto !== 1'b0) begin failed++; $display("FAIL reset_pronto: got %b want 0", pronto); end
    tests++; if (erro_paridade !== 1'b0) begin failed++; $display("FAIL reset_erro_paridade: got %b want 0", erro_paridade); end
    tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL reset_erro_frame: got %b want 0", erro_frame); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    tests++; if (db_estado !== 4'd0) begin failed++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
    $display("[TB] reset released");
  endtask

  task automatic test_valid();
    int pc;
    pc = pronto_cnt;
    send_frame(7'h23, 1'b1, 1'b1);
    @(negedge clock);
    tests++; if (pronto !== 1'b0) begin failed++; $display("FAIL valid_pronto_early: got %b want 0", pronto); end
    @(negedge clock);
    tests++; if (pronto !== 1'b1) begin failed++; $display("FAIL valid_pronto: got %b want 1", pronto); end
    tests++; if (dado_recebido !== 7'h23) begin failed++; $display("FAIL valid_dado: got %h want 23", dado_recebido); end
    tests++; if (tem_dado !== 1'b1) begin failed++; $display("FAIL valid_tem_dado: got %b want 1", tem_dado); end
    tests++; if (erro_paridade !== 1'b0) begin failed++; $display("FAIL valid_erro_paridade: got %b want 0", erro_paridade); end
    tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL valid_erro_frame: got %b want 0", erro_frame); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL valid_overrun: got %b want 0", overrun); end
    @(negedge clock);
    tests++; if (pronto !== 1'b0) begin failed++; $display("FAIL valid_pronto_width: got %b want 0", pronto); end
    pulse_recebe();
    tests++; if (tem_dado !== 1'b0) begin failed++; $display("FAIL valid_ack: got %b want 0", tem_dado); end
    tests++; if (pronto_cnt !== pc + 1) begin failed++; $display("FAIL valid_pulse_count: got %0d want %0d", pronto_cnt, pc + 1); end
  endtask

  task automatic test_parity();
    int pc;
    pc = pronto_cnt;
    send_frame(7'h41, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
`ifdef RX_PARITY_CHECK_EN
    tests++; if (erro_paridade !== 1'b1) begin failed++; $display("FAIL parity_flag: got %b want 1", erro_paridade); end
    tests++; if (pronto_cnt !== pc) begin failed++; $display("FAIL parity_no_pronto: got %0d want %0d", pronto_cnt, pc); end
    tests++; if (dado_recebido !== 7'h23) begin failed++; $display("FAIL parity_dado_held: got %h want 23", dado_recebido); end
    tests++; if (tem_dado !== 1'b0) begin failed++; $display("FAIL parity_tem_dado: got %b want 0", tem_dado); end
`else
    tests++; if (erro_paridade !== 1'b0) begin failed++; $display("FAIL parity_flag_off: got %b want 0", erro_paridade); end
    tests++; if (pronto_cnt !== pc + 1) begin failed++; $display("FAIL parity_pronto_off: got %0d want %0d", pronto_cnt, pc + 1); end
    tests++; if (dado_recebido !== 7'h41) begin failed++; $display("FAIL parity_dado_off: got %h want 41", dado_recebido); end
    tests++; if (tem_dado !== 1'b1) begin failed++; $display("FAIL parity_tem_dado_off: got %b want 1", tem_dado); end
    pulse_recebe();
`endif
    tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL parity_erro_frame: got %b want 0", erro_frame); end
  endtask

  task automatic test_break();
    int pc;
    pc = pronto_cnt;
    entrada_serial = 1'b0;
    repeat (60) @(negedge clock);
    tests++; if (db_estado !== 4'd0) begin failed++; $display("FAIL break_no_retrigger: got %0d want 0", db_estado); end
    tests++; if (erro_frame !== 1'b1) begin failed++; $display("FAIL break_erro_frame: got %b want 1", erro_frame); end
    entrada_serial = 1'b1;
    repeat (10) @(negedge clock);
    tests++; if (db_estado !== 4'd0) begin failed++; $display("FAIL break_idle_state: got %0d want 0", db_estado); end
    tests++; if (pronto_cnt !== pc) begin failed++; $display("FAIL break_no_pronto: got %0d want %0d", pronto_cnt, pc); end
    $display("[TB] break of 60 cycles done");
  endtask

  task automatic test_framing();
    int pc;
    pc = pronto_cnt;
    send_frame(7'h23, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL framing_cleared_by_valid: got %b want 0", erro_frame); end
    send_frame(7'h35, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    tests++; if (erro_frame !== 1'b1) begin failed++; $display("FAIL framing_flag: got %b want 1", erro_frame); end
    tests++; if (erro_paridade !== 1'b0) begin failed++; $display("FAIL framing_erro_paridade: got %b want 0", erro_paridade); end
    tests++; if (tem_dado !== 1'b1) begin failed++; $display("FAIL framing_tem_dado_held: got %b want 1", tem_dado); end
    tests++; if (dado_recebido !== 7'h23) begin failed++; $display("FAIL framing_dado_held: got %h want 23", dado_recebido); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL framing_no_overrun: got %b want 0", overrun); end
    tests++; if (pronto_cnt !== pc + 1) begin failed++; $display("FAIL framing_pulses: got %0d want %0d", pronto_cnt, pc + 1); end
    pulse_recebe();
    repeat (4) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int pc;
    pc = pronto_cnt;
    send_frame(7'h41, 1'b0, 1'b1);
    send_frame(7'h35, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    tests++; if (tem_dado !== 1'b1) begin failed++; $display("FAIL b2b_tem_dado: got %b want 1", tem_dado); end
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    tests++; if (dado_recebido !== 7'h35) begin failed++; $display("FAIL b2b_dado: got %h want 35", dado_recebido); end
    tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL b2b_erro_frame: got %b want 0", erro_frame); end
    tests++; if (pronto_cnt !== pc + 2) begin failed++; $display("FAIL b2b_pulses: got %0d want %0d", pronto_cnt, pc + 2); end
    pulse_recebe();
    tests++; if (tem_dado !== 1'b0) begin failed++; $display("FAIL b2b_ack_tem_dado: got %b want 0", tem_dado); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL b2b_ack_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_ack_collision();
    send_frame(7'h23, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    fork
      send_frame(7'h23, 1'b1, 1'b1);
      begin
        repeat (41) @(negedge clock);
        recebe = 1'b1;
        @(negedge clock);
        recebe = 1'b0;
        tests++; if (pronto !== 1'b1) begin failed++; $display("FAIL collide_pronto: got %b want 1", pronto); end
        tests++; if (tem_dado !== 1'b1) begin failed++; $display("FAIL collide_tem_dado: got %b want 1", tem_dado); end
        tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL collide_overrun: got %b want 0", overrun); end
      end
    join
    pulse_recebe();
  endtask

  task automatic test_glitch();
    int pc;
    pc = pronto_cnt;
    entrada_serial = 1'b0;
    repeat (2) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (2) @(negedge clock);
    tests++; if (db_estado !== 4'd1) begin failed++; $display("FAIL glitch_meio_start: got %0d want 1", db_estado); end
    @(negedge clock);
    tests++; if (db_estado !== 4'd0) begin failed++; $display("FAIL glitch_back_inicial: got %0d want 0", db_estado); end
    repeat (10) @(negedge clock);
    tests++; if (pronto_cnt !== pc) begin failed++; $display("FAIL glitch_no_pronto: got %0d want %0d", pronto_cnt, pc); end
    tests++; if (dado_recebido !== 7'h23) begin failed++; $display("FAIL glitch_dado: got %h want 23", dado_recebido); end
    tests++; if (tem_dado !== 1'b0) begin failed++; $display("FAIL glitch_tem_dado: got %b want 0", tem_dado); end
    tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL glitch_erro_frame: got %b want 0", erro_frame); end
    $display("[TB] glitch of 2 cycles done");
  endtask

  task automatic test_reset_midframe();
    int pc;
    send_frame(7'h23, 1'b1, 1'b1);
    send_frame(7'h23, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    tests++; if (overrun !== 1'b1) begin failed++; $display("FAIL midreset_pre_overrun: got %b want 1", overrun); end
    fork
      send_frame(7'h23, 1'b1, 1'b1);
      begin
        repeat (23) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tests++; if (dado_recebido !== 7'h00) begin failed++; $display("FAIL midreset_dado: got %h want 00", dado_recebido); end
        tests++; if (tem_dado !== 1'b0) begin failed++; $display("FAIL midreset_tem_dado: got %b want 0", tem_dado); end
        tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
        tests++; if (pronto !== 1'b0) begin failed++; $display("FAIL midreset_pronto: got %b want 0", pronto); end
        tests++; if (erro_frame !== 1'b0) begin failed++; $display("FAIL midreset_erro_frame: got %b want 0", erro_frame); end
        tests++; if (db_estado !== 4'd0) begin failed++; $display("FAIL midreset_estado: got %0d want 0", db_estado); end
      end
    join
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    pc = pronto_cnt;
    send_frame(7'h23, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    tests++; if (pronto !== 1'b1) begin failed++; $display("FAIL postreset_pronto: got %b want 1", pronto); end
    tests++; if (dado_recebido !== 7'h23) begin failed++; $display("FAIL postreset_dado: got %h want 23", dado_recebido); end
    tests++; if (tem_dado !== 1'b1) begin failed++; $display("FAIL postreset_tem_dado: got %b want 1", tem_dado); end
    tests++; if (overrun !== 1'b0) begin failed++; $display("FAIL postreset_overrun: got %b want 0", overrun); end
    repeat (2) @(negedge clock);
    tests++; if (pronto_cnt !== pc + 1) begin failed++; $display("FAIL postreset_pulses: got %0d want %0d", pronto_cnt, pc + 1); end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity();
    test_break();
    test_framing();
    test_back_to_back();
    test_ack_collision();
    test_glitch();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
